// File: rtl/axil_drain_pkg.sv
// Shared types and constants for the AXI-Lite FIFO drain master.
//   drain_state_e : FSM state encoding
//   axis_beat_t   : one AXI-Stream beat (data + last)
//   OFF_DATA / OFF_STAT : register offsets in the FIFO slave window
//   RESP_OKAY, STAT_EMPTY_BIT : response code and status-word bit positions
//   cnt_width()   : counter width able to hold 0..n-1 (at least 1 bit)
package axil_drain_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ST_AR,
        ST_R,
        GAP,
        DT_AR,
        DT_R,
        PUSH
    } drain_state_e;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic                  last;
    } axis_beat_t;

    localparam logic [3:0] OFF_DATA = 4'h4;
    localparam logic [3:0] OFF_STAT = 4'h8;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int unsigned STAT_EMPTY_BIT = 0;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axil_drain_out_reg.sv
// One-entry AXI-Stream output register.
//   clk, rst      : clock, asynchronous active-high reset
//   load          : capture load_beat and raise tvalid (only while tvalid=0)
//   load_beat     : data/last to present
//   tready        : downstream ready; tvalid drops on the handshake
//   tdata, tlast, tvalid : registered stream outputs
module axil_drain_out_reg
    import axil_drain_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  axis_beat_t            load_beat,
    input  logic                  tready,
    output logic [AXI_DATA_W-1:0] tdata,
    output logic                  tlast,
    output logic                  tvalid
);

    axis_beat_t beat_q;

    // Hold the beat until accepted; last is cleared so it never lingers without valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
            tvalid <= 1'b0;
        end else if (load) begin
            beat_q <= load_beat;
            tvalid <= 1'b1;
        end else if (tvalid && tready) begin
            beat_q.last <= 1'b0;
            tvalid      <= 1'b0;
        end
    end

    assign tdata = beat_q.data;
    assign tlast = beat_q.last;

endmodule

// File: rtl/axil_fifo_drain_master.sv
// AXI-Lite read-only master that drains a FIFO slave: polls status (BASE+0x08),
// reads one data word (BASE+0x04) when non-empty and forwards it on AXI-Stream.
// Ports:
//   m_axi_aclk, m_axi_areset : clock, asynchronous active-high reset
//   enable                   : run the polling engine
//   m_axi_ar* / m_axi_r*     : AXI-Lite read address / read data channels
//   m_axis_t*                : AXI-Stream output (one word outstanding at most)
//   busy                     : FSM not in IDLE
//   err                      : sticky, a read returned a non-OKAY response
//   word_cnt                 : words delivered on the stream, wraps
// Optional feature: define AXIL_DRAIN_TLAST_EN to build the packet counter that
// drives m_axis_tlast every PKT_LEN words; otherwise m_axis_tlast is constant 0.
module axil_fifo_drain_master
    import axil_drain_pkg::*;
#(
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = 32'h0,
    parameter int unsigned           POLL_GAP  = 16,
    parameter int unsigned           PKT_LEN   = 64,
    parameter int unsigned           CNT_W     = 32
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_areset,
    input  logic                  enable,
    output logic [AXI_ADDR_W-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [AXI_DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [AXI_DATA_W-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  err,
    output logic [CNT_W-1:0]      word_cnt
);

    localparam int unsigned           GAP_W     = cnt_width(POLL_GAP);
    localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(POLL_GAP - 1);
    localparam logic [AXI_ADDR_W-1:0] STAT_ADDR = BASE_ADDR + AXI_ADDR_W'(OFF_STAT);
    localparam logic [AXI_ADDR_W-1:0] DATA_ADDR = BASE_ADDR + AXI_ADDR_W'(OFF_DATA);

    // Elaboration-time guard on parameter ranges.
    if (POLL_GAP < 1 || PKT_LEN < 1) begin : g_bad_param
        $error("axil_fifo_drain_master: POLL_GAP and PKT_LEN must be >= 1");
    end

    drain_state_e          state_q, state_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic                  err_d;
    logic [CNT_W-1:0]      word_cnt_d;
    logic [AXI_ADDR_W-1:0] araddr_d;
    logic                  arvalid_d;
    logic                  rready_d;
    logic                  busy_d;
    logic                  load_c;
    logic                  beat_last_c;
    logic                  stream_hs_c;
    axis_beat_t            load_beat_c;

    assign stream_hs_c = m_axis_tvalid && m_axis_tready;
    assign load_beat_c = {m_axi_rdata, beat_last_c};

    // Next-state, counters and next values of the registered AXI outputs.
    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        err_d      = err;
        word_cnt_d = word_cnt;
        load_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                if (m_axi_arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (m_axi_rvalid) begin
                    if (m_axi_rresp != RESP_OKAY) begin
                        err_d   = 1'b1;
                        state_d = GAP;
                    end else if (m_axi_rdata[STAT_EMPTY_BIT]) begin
                        state_d = GAP;
                    end else if (enable) begin
                        state_d = DT_AR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = enable ? ST_AR : IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            DT_AR: begin
                if (m_axi_arready) begin
                    state_d = DT_R;
                end
            end
            DT_R: begin
                if (m_axi_rvalid) begin
                    if (m_axi_rresp != RESP_OKAY) begin
                        // Bad data read: word is dropped, go straight back to polling.
                        err_d   = 1'b1;
                        state_d = enable ? ST_AR : IDLE;
                    end else begin
                        load_c  = 1'b1;
                        state_d = PUSH;
                    end
                end
            end
            PUSH: begin
                if (stream_hs_c) begin
                    word_cnt_d = word_cnt + CNT_W'(1);
                    state_d    = enable ? ST_AR : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // AXI outputs follow the next state so they are registered yet aligned with it.
        arvalid_d = (state_d == ST_AR) || (state_d == DT_AR);
        rready_d  = (state_d == ST_R)  || (state_d == DT_R);
        busy_d    = (state_d != IDLE);
        if (state_d == ST_AR) begin
            araddr_d = STAT_ADDR;
        end else if (state_d == DT_AR) begin
            araddr_d = DATA_ADDR;
        end else begin
            araddr_d = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state_q       <= IDLE;
            gap_cnt_q     <= '0;
            err           <= 1'b0;
            word_cnt      <= '0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            gap_cnt_q     <= gap_cnt_d;
            err           <= err_d;
            word_cnt      <= word_cnt_d;
            m_axi_araddr  <= araddr_d;
            m_axi_arvalid <= arvalid_d;
            m_axi_rready  <= rready_d;
            busy          <= busy_d;
        end
    end

`ifdef AXIL_DRAIN_TLAST_EN
    localparam int unsigned      PKT_W    = cnt_width(PKT_LEN);
    localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PKT_LEN - 1);

    logic [PKT_W-1:0] pkt_cnt_q;

    // Position of the next word within its packet; survives enable toggles.
    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            pkt_cnt_q <= '0;
        end else if (stream_hs_c) begin
            pkt_cnt_q <= (pkt_cnt_q == PKT_LAST) ? '0 : pkt_cnt_q + PKT_W'(1);
        end
    end

    assign beat_last_c = (pkt_cnt_q == PKT_LAST);
`else
    assign beat_last_c = 1'b0;
`endif

    axil_drain_out_reg u_out_reg (
        .clk       (m_axi_aclk),
        .rst       (m_axi_areset),
        .load      (load_c),
        .load_beat (load_beat_c),
        .tready    (m_axis_tready),
        .tdata     (m_axis_tdata),
        .tlast     (m_axis_tlast),
        .tvalid    (m_axis_tvalid)
    );

endmodule

// File: tb/tb_axil_fifo_drain_master.sv
// Self-checking bench for axil_fifo_drain_master: FIFO slave model on AR/R,
// stream sink with a scoreboard, table-driven drain scenarios and hand-written
// corner sequences (stall, error, enable drop, async reset mid-PUSH).
module tb_axil_fifo_drain_master;

    localparam logic [31:0] BASE     = 32'h4000_1000;
    localparam int unsigned POLL_GAP = 4;
    localparam int unsigned PKT_LEN  = 4;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned AR_WAIT  = 1;
    localparam logic [31:0] STAT_A   = BASE + 32'h8;
    localparam logic [31:0] DATA_A   = BASE + 32'h4;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        int unsigned      n_words;
        logic [31:0]      first;
        logic [31:0]      step;
        int unsigned      stall;
        int unsigned      inj_err;
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_err;
    } row_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b1;
    logic [31:0]      m_axi_araddr;
    logic             m_axi_arvalid;
    logic             m_axi_arready = 1'b0;
    logic [31:0]      m_axi_rdata = '0;
    logic [1:0]       m_axi_rresp = '0;
    logic             m_axi_rvalid = 1'b0;
    logic             m_axi_rready;
    logic [31:0]      m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b0;
    logic             m_axis_tlast;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] word_cnt;

    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned viol = 0;
    int unsigned cyc = 0;
    int unsigned ar_total = 0;
    int unsigned stream_words = 0;
    int unsigned tvalid_seen = 0;
    int unsigned inj_err = 0;
    int unsigned pkt_idx = 0;
    bit          tready_req = 1'b1;
    bit          drop_en_on_data = 1'b0;
    logic [31:0] fifo[$];
    beat_t       sb[$];
    int unsigned stat_hs_cyc[$];

    always #5 clk = ~clk;

    axil_fifo_drain_master #(
        .BASE_ADDR (BASE),
        .POLL_GAP  (POLL_GAP),
        .PKT_LEN   (PKT_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .m_axi_aclk    (clk),
        .m_axi_areset  (rst),
        .enable        (enable),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .err           (err),
        .word_cnt      (word_cnt)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic violation(input string name);
        viol++;
        $display("FAIL proto %s at cycle %0d", name, cyc);
    endtask

    function automatic logic exp_last(input int unsigned idx);
`ifdef AXIL_DRAIN_TLAST_EN
        return (idx % PKT_LEN) == (PKT_LEN - 1);
`else
        return 1'b0 & idx[0];
`endif
    endfunction

    // Slave model, stream sink, scoreboard compare and protocol monitors.
    // Everything runs on the falling edge: DUT outputs are stable there and the
    // values saved here are exactly what the DUT sees at the next rising edge.
    initial begin : bus
        logic        av_p, ardy_p, rv_p, rr_p, tv_p, tr_p, tl_p;
        logic [31:0] aa_p, td_p, d;
        int unsigned ar_age;
        beat_t       e;
        av_p = 0; ardy_p = 0; rv_p = 0; rr_p = 0; tv_p = 0; tr_p = 0; tl_p = 0;
        aa_p = '0; td_p = '0; ar_age = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                m_axi_arready = 1'b0;
                m_axi_rvalid  = 1'b0;
                m_axis_tready = tready_req;
                ar_age = 0;
                av_p = 0; ardy_p = 0; rv_p = 0; rr_p = 0; tv_p = 0; tr_p = 0;
            end else begin
                if (tv_p && !tr_p && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== td_p || m_axis_tlast !== tl_p))
                    violation("stream_not_held");
                if (av_p && !ardy_p && (m_axi_arvalid !== 1'b1 || m_axi_araddr !== aa_p))
                    violation("ar_not_held");
                if (m_axi_arvalid && m_axis_tvalid) violation("ar_while_tvalid");
                if (m_axi_arvalid && m_axi_rready) violation("arvalid_with_rready");
                if (m_axis_tvalid) tvalid_seen++;

                if (tv_p && tr_p) begin
                    stream_words++;
                    if (sb.size() == 0) begin
                        checks++;
                        $display("FAIL stream_unexpected: got word 0x%0h, expected none", td_p);
                    end else begin
                        e = sb.pop_front();
                        check("stream_beat", {td_p, tl_p}, {e.data, e.last});
                    end
                end

                if (rv_p && rr_p) m_axi_rvalid = 1'b0;

                if (av_p && ardy_p) begin
                    m_axi_arready = 1'b0;
                    ar_age = 0;
                    ar_total++;
                    m_axi_rvalid = 1'b1;
                    m_axi_rresp  = 2'b00;
                    if (aa_p == STAT_A) begin
                        stat_hs_cyc.push_back(cyc);
                        m_axi_rdata = ($urandom() & 32'hFFFF_FFFE) | ((fifo.size() == 0) ? 32'h1 : 32'h0);
                    end else if (aa_p == DATA_A) begin
                        if (drop_en_on_data) begin
                            enable = 1'b0;
                            drop_en_on_data = 1'b0;
                        end
                        if (inj_err > 0) begin
                            inj_err--;
                            m_axi_rresp = 2'b10;
                            m_axi_rdata = 32'hBAD0_BAD0;
                        end else if (fifo.size() == 0) begin
                            violation("data_read_on_empty");
                            m_axi_rresp = 2'b10;
                            m_axi_rdata = '0;
                        end else begin
                            d = fifo.pop_front();
                            m_axi_rdata = d;
                            sb.push_back({d, exp_last(pkt_idx)});
                            pkt_idx++;
                        end
                    end else begin
                        violation("bad_araddr");
                        m_axi_rdata = '0;
                    end
                end else if (m_axi_arvalid) begin
                    ar_age++;
                    if (ar_age > AR_WAIT) m_axi_arready = 1'b1;
                end

                m_axis_tready = tready_req;
                av_p = m_axi_arvalid;  ardy_p = m_axi_arready; aa_p = m_axi_araddr;
                rv_p = m_axi_rvalid;   rr_p = m_axi_rready;
                tv_p = m_axis_tvalid;  tr_p = m_axis_tready;
                td_p = m_axis_tdata;   tl_p = m_axis_tlast;
            end
        end
    end

    task automatic wait_tvalid(input int unsigned limit, input string name);
        int unsigned t = 0;
        while (m_axis_tvalid !== 1'b1 && t < limit) begin @(negedge clk); t++; end
        if (m_axis_tvalid !== 1'b1) begin
            checks++;
            $display("FAIL %s: tvalid=%0b after %0d cycles, expected 1", name, m_axis_tvalid, t);
        end
    endtask

    task automatic wait_drained(input int unsigned limit, input string name);
        int unsigned t = 0;
        while ((fifo.size() != 0 || sb.size() != 0) && t < limit) begin @(negedge clk); t++; end
        if (fifo.size() != 0 || sb.size() != 0) begin
            checks++;
            $display("FAIL %s: fifo=%0d sb=%0d left after %0d cycles, expected 0/0", name, fifo.size(), sb.size(), t);
        end
    endtask

    task automatic run_row(input row_t r);
        int unsigned sw0 = stream_words;
        int unsigned ar0;
        inj_err = r.inj_err;
        if (r.stall != 0) tready_req = 1'b0;
        for (int k = 0; k < int'(r.n_words); k++) fifo.push_back(r.first + r.step * 32'(k));
        if (r.stall != 0) begin
            wait_tvalid(200, "stall_first_word");
            ar0 = ar_total;
            repeat (r.stall) @(negedge clk);
            check("stall_tdata", {m_axis_tvalid, m_axis_tdata}, {1'b1, r.first});
            check("stall_no_ar", ar_total - ar0, 0);
            tready_req = 1'b1;
        end
        wait_drained(20 * r.n_words + 400, "row_drain");
        repeat (20) @(negedge clk);
        check("row_words", stream_words - sw0, r.n_words);
        check("row_word_cnt", word_cnt, r.exp_cnt);
        check("row_err", err, r.exp_err);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : test
        row_t        rows[5];
        row_t        after_rst;
        logic [CNT_W-1:0] wc0;
        int unsigned ar0, t;

        rows[0] = '{3,   32'h0000_0011, 32'h0000_0011, 0,  0, 8'd3, 1'b0};
        rows[1] = '{2,   32'hA5A5_0001, 32'h0000_0001, 50, 0, 8'd5, 1'b0};
        rows[2] = '{1,   32'hDEAD_DEAD, 32'h0000_0000, 0,  0, 8'd6, 1'b0};
        rows[3] = '{3,   32'h0000_0101, 32'h0000_0101, 0,  1, 8'd9, 1'b1};
        rows[4] = '{250, 32'h8000_0000, 32'h0000_0003, 0,  0, 8'd3, 1'b1};
        after_rst = '{5, 32'hC0DE_0000, 32'h0000_0001, 0, 0, 8'd5, 1'b0};

        // Reset with enable high and an empty slave.
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {m_axi_araddr, m_axi_arvalid, m_axi_rready, m_axis_tdata, m_axis_tvalid,
               m_axis_tlast, busy, err, word_cnt}, '0);
        rst = 1'b0;
        stat_hs_cyc.delete();
        tvalid_seen = 0;
        repeat (60) @(negedge clk);
        if (stat_hs_cyc.size() < 4) begin
            checks++;
            $display("FAIL poll_count: got %0d status reads, expected >= 4", stat_hs_cyc.size());
        end else begin
            for (int i = 1; i < 4; i++)
                check("poll_interval", stat_hs_cyc[i] - stat_hs_cyc[i-1], POLL_GAP + AR_WAIT + 2);
        end
        check("empty_no_tvalid", tvalid_seen, 0);
        check("empty_word_cnt", word_cnt, 0);
        check("empty_busy_err", {busy, err}, 2'b10);

        // Table-driven drain scenarios.
        for (int i = 0; i < 5; i++) run_row(rows[i]);

        // enable drops while the data read is in flight.
        wc0 = word_cnt;
        fifo.push_back(32'h5150_0001);
        fifo.push_back(32'h5150_0002);
        drop_en_on_data = 1'b1;
        t = 0;
        while (enable && t < 200) begin @(negedge clk); t++; end
        t = 0;
        while (busy !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        ar0 = ar_total;
        repeat (30) @(negedge clk);
        check("drop_busy", busy, 1'b0);
        check("drop_word_cnt", word_cnt, CNT_W'(wc0 + 1));
        check("drop_no_ar", ar_total - ar0, 0);
        check("drop_fifo_left", fifo.size(), 1);
        enable = 1'b1;
        wait_drained(200, "drop_resume");
        repeat (5) @(negedge clk);
        check("drop_resume_cnt", word_cnt, CNT_W'(wc0 + 2));

        // Asynchronous reset while a word waits in PUSH.
        tready_req = 1'b0;
        fifo.push_back(32'h7777_0001);
        wait_tvalid(200, "rst_push_word");
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs",
                 {m_axi_araddr, m_axi_arvalid, m_axi_rready, m_axis_tdata, m_axis_tvalid,
                  m_axis_tlast, busy, err, word_cnt}, '0);
        fifo.delete();
        sb.delete();
        inj_err = 0;
        pkt_idx = 0;
        tready_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_reset_cnt_err", {word_cnt, err}, '0);
        run_row(after_rst);

        check("protocol_violations", viol, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
